strum_sequencer: RTL and testbench
==================================

# strum_sequencer

Output sequencer between the five fret detectors and the guitar-controller outputs. It turns one-cycle note-hit pulses into a correctly ordered controller action:
- gather simultaneous hits into a chord;
- press the frets and let them settle;
- strum for a programmable number of frames;
- hold sustained frets, then enforce a cooldown before the next strum.

One hit arriving while busy is buffered; further hits are dropped and counted.

## Interface
Parameters:
- CHORD_WIN, 64: cycles after the first hit during which further hits join the chord (≥1).
- SETTLE, 16: cycles frets are held before Strum rises (≥1).
- GAP, 2: FrameTick pulses of cooldown after release (0 = none).

Ports:
- CLK  in  1  pixel clock; the only clock.
- RST_N  in  1  synchronous, active-low reset.
- Enable  in  1  0 forces IDLE, zero outputs, pending cleared.
- FrameTick  in  1  one-cycle pulse per video frame.
- NoteHit  in  5  per-fret hit pulses {O,B,Y,R,G}.
- NoteHeld  in  5  per-fret sustain level.
- StrumTime  in  4  strum length in FrameTicks; 0 is treated as 1.
- Frets  out  5  registered fret drive.
- Strum  out  1  registered strum drive.
- Busy  out  1  state ≠ IDLE.
- Dropped  out  8  saturating count of discarded hits.
- State  out  3  current state encoding (debug/status).

## Operation
States, with encoding:
- IDLE (0)
  - NoteHit ≠ 0 → mask ← NoteHit, load timer with CHORD_WIN, go to GATHER.
  - Otherwise, if pending valid → mask ← pending, clear pending, load timer with CHORD_WIN, go to GATHER.
  - When a hit and a pending mask coincide: mask ← NoteHit | pending, clear pending.
- GATHER (1)
  - mask |= NoteHit each cycle.
  - Timer expires → load timer with SETTLE, go to SETTLE.
- SETTLE (2)
  - New hits go to pending.
  - Timer expires → load tick counter with max(StrumTime,1), go to STRUM.
- STRUM (3)
  - Strum = 1.
  - Decrement on each FrameTick; FrameTick with count == 1 → RELEASE.
- RELEASE (4)
  - mask ← mask & NoteHeld each cycle.
  - mask becomes 0 → COOLDOWN with count GAP, or IDLE if GAP = 0.
- COOLDOWN (5)
  - Decrement on FrameTick; count reaches 0 → IDLE.

Outputs and pending rules:
- Frets = mask in GATHER, SETTLE, STRUM and RELEASE; 0 in IDLE and COOLDOWN.
- Pending buffer: 5-bit mask plus a valid bit. A hit in states 2–5:
  - pending invalid → pending ← NoteHit, set valid.
  - pending valid → Dropped += 1, saturating at 255; the hit is discarded.
- Enable = 0:
  - Next cycle: IDLE, Frets = 0, Strum = 0, pending cleared.
  - Dropped is held; hits are ignored and not counted.
- Reset: state IDLE, Frets 0, Strum 0, Busy 0, Dropped 0, pending cleared, timers 0.
- StrumTime is sampled only on SETTLE→STRUM; later changes do not affect the strum in progress.

## Timing
- All outputs are registered.
- Hit at IDLE in cycle 0:
  - Frets valid from cycle 1.
  - GATHER covers cycles 1..CHORD_WIN.
  - SETTLE covers CHORD_WIN+1..CHORD_WIN+SETTLE.
  - Strum rises at cycle CHORD_WIN+SETTLE+1.
- Strum length is between max(StrumTime,1)−1 and max(StrumTime,1) frames, because the first FrameTick phase is arbitrary.
- Strum falls the cycle after the terminating FrameTick. Frets stay at mask & NoteHeld.
- A FrameTick coincident with STRUM entry is not counted.
- A FrameTick coincident with COOLDOWN entry is not counted.
- A hit coincident with the GATHER→SETTLE transition goes to pending, not mask.
- Pending-to-GATHER costs one IDLE cycle.

## Structure
- Shared package `player_pkg`:
  - state enum (3-bit encodings above);
  - FRET_W = 5;
  - DROP_W = 8.
- Sub-module `strum_timer`:
  - 8-bit loadable down-counter;
  - decrement-enable input, selected as every cycle or FrameTick;
  - `done` output.
  - One instance serves the cycle timer and the tick counter, since only one is live per state.

## Test plan
Bench parameters: CHORD_WIN=4, SETTLE=2, GAP=1, StrumTime=2, FrameTick every 10 cycles, NoteHeld=0 unless stated.
- NoteHit=00001 at cycle 0 → Frets=00001 from cycle 1; Strum rises at cycle 7; Strum falls the cycle after the 2nd counted FrameTick; Frets=0 the following cycle.
- Hits 00001 at cycle 0 and 00100 at cycle 3 → Frets=00101 at cycle 4; a hit at cycle 5 goes to pending.
- Hold NoteHeld=00010 with chord 00011 → after Strum falls, Frets=00010 until NoteHeld drops, then Frets=0, COOLDOWN, IDLE.
- Three hits during STRUM → the first is pending and replays into GATHER one cycle after IDLE; Dropped=2.
- Enable→0 mid-STRUM → next cycle Strum=0, Frets=0, State=0; pending cleared; Dropped unchanged.
- 300 hits while pending valid → Dropped saturates at 255.
- RST_N low mid-SETTLE → all outputs zero on the next edge.

Source files
------------

// File: rtl/player_pkg.sv
// Shared types and widths for the guitar-controller player datapath.
package player_pkg;

  localparam int FRET_W  = 5;
  localparam int DROP_W  = 8;
  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GATHER   = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_STRUM    = 3'd3,
    ST_RELEASE  = 3'd4,
    ST_COOLDOWN = 3'd5
  } state_t;

  // A strum length of zero frames is meaningless, so it is promoted to one.
  function automatic logic [TIMER_W-1:0] strumLen(input logic [3:0] t);
    return (t == 4'd0) ? TIMER_W'(1) : TIMER_W'(t);
  endfunction

endpackage

// File: rtl/strum_timer.sv
// Loadable down-counter shared by the cycle timer and the FrameTick counter.
module strum_timer
  import player_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rstN,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_loadVal,
  input  logic               i_dec,
  output logic               o_done
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - TIMER_W'(1);
    end
  end

  // Expiry is the decrement step that takes the last unit off the count.
  assign o_done = i_dec && (r_count <= TIMER_W'(1));

endmodule

// File: rtl/strum_sequencer.sv
// Turns fret-detector hit pulses into an ordered press/settle/strum/release
// sequence on the controller outputs, buffering one early hit.
module strum_sequencer
  import player_pkg::*;
#(
  parameter int CHORD_WIN = 64,
  parameter int SETTLE    = 16,
  parameter int GAP       = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Enable,
  input  logic              FrameTick,
  input  logic [FRET_W-1:0] NoteHit,
  input  logic [FRET_W-1:0] NoteHeld,
  input  logic [3:0]        StrumTime,
  output logic [FRET_W-1:0] Frets,
  output logic              Strum,
  output logic              Busy,
  output logic [DROP_W-1:0] Dropped,
  output logic [2:0]        State
);

  state_t              r_state;
  logic [FRET_W-1:0]   r_mask;
  logic                r_strum;
  logic                r_busy;
  logic                r_pendValid;
  logic [FRET_W-1:0]   r_pendMask;
  logic [DROP_W-1:0]   r_dropped;

  logic                w_hit;
  logic                w_capture;
  logic [FRET_W-1:0]   w_heldMask;
  logic                w_timerLoad;
  logic [TIMER_W-1:0]  w_timerLoadVal;
  logic                w_timerDec;
  logic                w_timerDone;

  assign w_hit      = |NoteHit;
  assign w_heldMask = r_mask & NoteHeld;

  // Hits arriving once the chord is closed (including its closing cycle) go to pending.
  assign w_capture = w_hit &&
                     ((r_state == ST_SETTLE) || (r_state == ST_STRUM) ||
                      (r_state == ST_RELEASE) || (r_state == ST_COOLDOWN) ||
                      ((r_state == ST_GATHER) && w_timerDone));

  // Timer reload mirrors the FSM transitions; the strum and cooldown phases count frames.
  always_comb begin
    w_timerLoad    = 1'b0;
    w_timerLoadVal = '0;
    w_timerDec     = 1'b1;
    if ((r_state == ST_STRUM) || (r_state == ST_COOLDOWN)) begin
      w_timerDec = FrameTick;
    end
    if (!Enable) begin
      w_timerLoad = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit || r_pendValid) begin
            w_timerLoad    = 1'b1;
            w_timerLoadVal = TIMER_W'(CHORD_WIN);
          end
        end
        ST_GATHER: begin
          if (w_timerDone) begin
            w_timerLoad    = 1'b1;
            w_timerLoadVal = TIMER_W'(SETTLE);
          end
        end
        ST_SETTLE: begin
          if (w_timerDone) begin
            w_timerLoad    = 1'b1;
            w_timerLoadVal = strumLen(StrumTime);
          end
        end
        ST_RELEASE: begin
          if (w_heldMask == '0) begin
            w_timerLoad    = 1'b1;
            w_timerLoadVal = TIMER_W'(GAP);
          end
        end
        default: begin
          w_timerLoad = 1'b0;
        end
      endcase
    end
  end

  strum_timer u_timer (
    .i_clk     (CLK),
    .i_rstN    (RST_N),
    .i_load    (w_timerLoad),
    .i_loadVal (w_timerLoadVal),
    .i_dec     (w_timerDec),
    .o_done    (w_timerDone)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_strum     <= 1'b0;
      r_busy      <= 1'b0;
      r_pendValid <= 1'b0;
      r_pendMask  <= '0;
      r_dropped   <= '0;
    end else if (!Enable) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_strum     <= 1'b0;
      r_busy      <= 1'b0;
      r_pendValid <= 1'b0;
      r_pendMask  <= '0;
    end else begin
      if (w_capture) begin
        if (!r_pendValid) begin
          r_pendValid <= 1'b1;
          r_pendMask  <= NoteHit;
        end else if (r_dropped != '1) begin
          r_dropped <= r_dropped + DROP_W'(1);
        end
      end
      // r_mask is kept at zero outside GATHER..RELEASE so it can drive Frets directly.
      case (r_state)
        ST_IDLE: begin
          if (w_hit || r_pendValid) begin
            r_mask      <= NoteHit | r_pendMask;
            r_pendValid <= 1'b0;
            r_pendMask  <= '0;
            r_state     <= ST_GATHER;
            r_busy      <= 1'b1;
          end
        end
        ST_GATHER: begin
          if (w_timerDone) begin
            r_state <= ST_SETTLE;
          end else begin
            r_mask <= r_mask | NoteHit;
          end
        end
        ST_SETTLE: begin
          if (w_timerDone) begin
            r_state <= ST_STRUM;
            r_strum <= 1'b1;
          end
        end
        ST_STRUM: begin
          if (w_timerDone) begin
            r_state <= ST_RELEASE;
            r_strum <= 1'b0;
          end
        end
        ST_RELEASE: begin
          r_mask <= w_heldMask;
          if (w_heldMask == '0) begin
            if (GAP == 0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_COOLDOWN;
            end
          end
        end
        ST_COOLDOWN: begin
          if (w_timerDone) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_mask  <= '0;
          r_strum <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Frets   = r_mask;
  assign Strum   = r_strum;
  assign Busy    = r_busy;
  assign Dropped = r_dropped;
  assign State   = r_state;

endmodule

// File: tb/tb_strum_sequencer.sv
// Directed bench for strum_sequencer: a cycle-by-cycle vector table for one full
// strum plus hand-written sequences for chords, pending, enable, saturation and reset.
module tb_strum_sequencer;
  import player_pkg::*;

  localparam int CW = 4;
  localparam int SW = 2;
  localparam int GP = 1;

  logic              clk = 1'b0;
  logic              rstN;
  logic              Enable;
  logic              FrameTick;
  logic [FRET_W-1:0] NoteHit;
  logic [FRET_W-1:0] NoteHeld;
  logic [3:0]        StrumTime;
  logic [FRET_W-1:0] Frets;
  logic              Strum;
  logic              Busy;
  logic [DROP_W-1:0] Dropped;
  logic [2:0]        State;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0] hit;
    logic [4:0] held;
    logic       tick;
    logic [4:0] expFrets;
    logic       expStrum;
    logic [2:0] expState;
    logic       expBusy;
    logic [7:0] expDropped;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  strum_sequencer #(.CHORD_WIN(CW), .SETTLE(SW), .GAP(GP)) dut (
    .CLK       (clk),
    .RST_N     (rstN),
    .Enable    (Enable),
    .FrameTick (FrameTick),
    .NoteHit   (NoteHit),
    .NoteHeld  (NoteHeld),
    .StrumTime (StrumTime),
    .Frets     (Frets),
    .Strum     (Strum),
    .Busy      (Busy),
    .Dropped   (Dropped),
    .State     (State)
  );

  // Drive one cycle of inputs, then sample #1 after the edge that consumed them.
  task automatic applyStimulus(input logic [4:0] hit, input logic [4:0] held,
                               input logic tick, input logic en);
    NoteHit   = hit;
    NoteHeld  = held;
    FrameTick = tick;
    Enable    = en;
    @(posedge clk);
    #1;
    NoteHit   = '0;
    FrameTick = 1'b0;
  endtask

  task automatic stepN(input int n, input logic [4:0] hit, input logic [4:0] held);
    for (int i = 0; i < n; i++) applyStimulus(hit, held, 1'b0, 1'b1);
  endtask

  // Nine quiet cycles followed by one FrameTick, matching a 10-cycle frame.
  task automatic frame(input logic [4:0] held);
    stepN(9, 5'b0, held);
    applyStimulus(5'b0, held, 1'b1, 1'b1);
  endtask

  task automatic checkOutput(input string name, input logic [4:0] eFrets, input logic eStrum,
                             input logic [2:0] eState, input logic eBusy, input logic [7:0] eDropped);
    vectors++;
    if (Frets !== eFrets || Strum !== eStrum || State !== eState ||
        Busy !== eBusy || Dropped !== eDropped) begin
      miscompares++;
      $display("[TB] FAIL %s: got Frets=%b Strum=%b State=%0d Busy=%b Dropped=%0d, expected Frets=%b Strum=%b State=%0d Busy=%b Dropped=%0d",
               name, Frets, Strum, State, Busy, Dropped, eFrets, eStrum, eState, eBusy, eDropped);
    end
  endtask

  task automatic doReset();
    rstN = 1'b0;
    applyStimulus(5'b0, 5'b0, 1'b0, 1'b1);
    applyStimulus(5'b0, 5'b0, 1'b0, 1'b1);
    rstN = 1'b1;
  endtask

  function automatic void addVec(input logic [4:0] hit, input logic tick, input logic [4:0] eFrets,
                                 input logic eStrum, input logic [2:0] eState, input logic eBusy);
    vec_t v;
    v.hit = hit; v.held = 5'b0; v.tick = tick;
    v.expFrets = eFrets; v.expStrum = eStrum; v.expState = eState;
    v.expBusy = eBusy; v.expDropped = 8'd0;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0; Enable = 1'b1; FrameTick = 1'b0;
    NoteHit = '0; NoteHeld = '0; StrumTime = 4'd2;

    // Single note, cycle 0 hit; entry i holds cycle i inputs and cycle i+1 outputs.
    addVec(5'b00001, 1'b0, 5'b00001, 1'b0, ST_GATHER, 1'b1);
    for (int c = 1; c <= 3; c++)   addVec(5'b0, 1'b0, 5'b00001, 1'b0, ST_GATHER, 1'b1);
    for (int c = 4; c <= 5; c++)   addVec(5'b0, 1'b0, 5'b00001, 1'b0, ST_SETTLE, 1'b1);
    for (int c = 6; c <= 18; c++)  addVec(5'b0, (c == 9), 5'b00001, 1'b1, ST_STRUM, 1'b1);
    addVec(5'b0, 1'b1, 5'b00001, 1'b0, ST_RELEASE, 1'b1);
    for (int c = 20; c <= 28; c++) addVec(5'b0, 1'b0, 5'b00000, 1'b0, ST_COOLDOWN, 1'b1);
    addVec(5'b0, 1'b1, 5'b00000, 1'b0, ST_IDLE, 1'b0);

    doReset();
    checkOutput("reset", 5'b0, 1'b0, ST_IDLE, 1'b0, 8'd0);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].hit, vecs[i].held, vecs[i].tick, 1'b1);
      checkOutput($sformatf("single_c%0d", i + 1), vecs[i].expFrets, vecs[i].expStrum,
                  vecs[i].expState, vecs[i].expBusy, vecs[i].expDropped);
    end

    // Chord 00001+00100, then a SETTLE hit that must replay after cooldown.
    doReset();
    applyStimulus(5'b00001, 5'b0, 1'b0, 1'b1);
    stepN(2, 5'b0, 5'b0);
    applyStimulus(5'b00100, 5'b0, 1'b0, 1'b1);
    checkOutput("chord_c4", 5'b00101, 1'b0, ST_GATHER, 1'b1, 8'd0);
    stepN(1, 5'b0, 5'b0);
    applyStimulus(5'b00010, 5'b0, 1'b0, 1'b1);
    checkOutput("chord_pend_c6", 5'b00101, 1'b0, ST_SETTLE, 1'b1, 8'd0);
    stepN(1, 5'b0, 5'b0);
    checkOutput("chord_strum", 5'b00101, 1'b1, ST_STRUM, 1'b1, 8'd0);
    frame(5'b0);
    frame(5'b0);
    checkOutput("chord_release", 5'b00101, 1'b0, ST_RELEASE, 1'b1, 8'd0);
    stepN(1, 5'b0, 5'b0);
    checkOutput("chord_cool", 5'b0, 1'b0, ST_COOLDOWN, 1'b1, 8'd0);
    frame(5'b0);
    checkOutput("chord_idle", 5'b0, 1'b0, ST_IDLE, 1'b0, 8'd0);
    stepN(1, 5'b0, 5'b0);
    checkOutput("chord_replay", 5'b00010, 1'b0, ST_GATHER, 1'b1, 8'd0);

    // Sustained fret keeps Frets after Strum falls.
    doReset();
    applyStimulus(5'b00011, 5'b00010, 1'b0, 1'b1);
    stepN(6, 5'b0, 5'b00010);
    checkOutput("held_strum", 5'b00011, 1'b1, ST_STRUM, 1'b1, 8'd0);
    frame(5'b00010);
    frame(5'b00010);
    checkOutput("held_release0", 5'b00011, 1'b0, ST_RELEASE, 1'b1, 8'd0);
    stepN(4, 5'b0, 5'b00010);
    checkOutput("held_sustain", 5'b00010, 1'b0, ST_RELEASE, 1'b1, 8'd0);
    stepN(1, 5'b0, 5'b0);
    checkOutput("held_drop", 5'b0, 1'b0, ST_COOLDOWN, 1'b1, 8'd0);
    frame(5'b0);
    checkOutput("held_idle", 5'b0, 1'b0, ST_IDLE, 1'b0, 8'd0);

    // Three hits during STRUM: one pending, two dropped.
    doReset();
    applyStimulus(5'b00001, 5'b0, 1'b0, 1'b1);
    stepN(6, 5'b0, 5'b0);
    applyStimulus(5'b00100, 5'b0, 1'b0, 1'b1);
    checkOutput("drop_h1", 5'b00001, 1'b1, ST_STRUM, 1'b1, 8'd0);
    applyStimulus(5'b01000, 5'b0, 1'b0, 1'b1);
    checkOutput("drop_h2", 5'b00001, 1'b1, ST_STRUM, 1'b1, 8'd1);
    applyStimulus(5'b10000, 5'b0, 1'b0, 1'b1);
    checkOutput("drop_h3", 5'b00001, 1'b1, ST_STRUM, 1'b1, 8'd2);
    stepN(6, 5'b0, 5'b0);
    applyStimulus(5'b0, 5'b0, 1'b1, 1'b1);
    frame(5'b0);
    checkOutput("drop_release", 5'b00001, 1'b0, ST_RELEASE, 1'b1, 8'd2);
    stepN(1, 5'b0, 5'b0);
    frame(5'b0);
    checkOutput("drop_idle", 5'b0, 1'b0, ST_IDLE, 1'b0, 8'd2);
    stepN(1, 5'b0, 5'b0);
    checkOutput("drop_replay", 5'b00100, 1'b0, ST_GATHER, 1'b1, 8'd2);

    // Tick on STRUM entry is ignored; StrumTime change mid-strum is ignored.
    doReset();
    applyStimulus(5'b00001, 5'b0, 1'b0, 1'b1);
    stepN(5, 5'b0, 5'b0);
    applyStimulus(5'b0, 5'b0, 1'b1, 1'b1);
    checkOutput("entry_tick", 5'b00001, 1'b1, ST_STRUM, 1'b1, 8'd0);
    StrumTime = 4'd0;
    applyStimulus(5'b0, 5'b0, 1'b1, 1'b1);
    checkOutput("entry_first", 5'b00001, 1'b1, ST_STRUM, 1'b1, 8'd0);
    applyStimulus(5'b0, 5'b0, 1'b1, 1'b1);
    checkOutput("entry_second", 5'b00001, 1'b0, ST_RELEASE, 1'b1, 8'd0);

    // StrumTime = 0 behaves as a one-frame strum.
    doReset();
    applyStimulus(5'b00001, 5'b0, 1'b0, 1'b1);
    stepN(6, 5'b0, 5'b0);
    applyStimulus(5'b0, 5'b0, 1'b1, 1'b1);
    checkOutput("st0_release", 5'b00001, 1'b0, ST_RELEASE, 1'b1, 8'd0);
    StrumTime = 4'd2;

    // Enable low mid-STRUM clears everything except Dropped.
    doReset();
    applyStimulus(5'b00001, 5'b0, 1'b0, 1'b1);
    stepN(6, 5'b0, 5'b0);
    applyStimulus(5'b00010, 5'b0, 1'b0, 1'b1);
    applyStimulus(5'b00100, 5'b0, 1'b0, 1'b1);
    applyStimulus(5'b01000, 5'b0, 1'b0, 1'b0);
    checkOutput("en_off", 5'b0, 1'b0, ST_IDLE, 1'b0, 8'd1);
    applyStimulus(5'b00100, 5'b0, 1'b0, 1'b0);
    checkOutput("en_ignore", 5'b0, 1'b0, ST_IDLE, 1'b0, 8'd1);
    applyStimulus(5'b0, 5'b0, 1'b0, 1'b1);
    checkOutput("en_no_pend", 5'b0, 1'b0, ST_IDLE, 1'b0, 8'd1);

    // Dropped saturates at 255.
    doReset();
    applyStimulus(5'b00001, 5'b0, 1'b0, 1'b1);
    stepN(6, 5'b0, 5'b0);
    applyStimulus(5'b00001, 5'b0, 1'b0, 1'b1);
    stepN(254, 5'b00001, 5'b0);
    checkOutput("sat_254", 5'b00001, 1'b1, ST_STRUM, 1'b1, 8'd254);
    stepN(46, 5'b00001, 5'b0);
    checkOutput("sat_255", 5'b00001, 1'b1, ST_STRUM, 1'b1, 8'd255);
    applyStimulus(5'b0, 5'b0, 1'b0, 1'b0);
    checkOutput("sat_hold", 5'b0, 1'b0, ST_IDLE, 1'b0, 8'd255);

    // Reset mid-SETTLE clears outputs including Dropped.
    applyStimulus(5'b00001, 5'b0, 1'b0, 1'b1);
    stepN(4, 5'b0, 5'b0);
    checkOutput("rst_settle", 5'b00001, 1'b0, ST_SETTLE, 1'b1, 8'd255);
    rstN = 1'b0;
    applyStimulus(5'b0, 5'b0, 1'b0, 1'b1);
    checkOutput("rst_clear", 5'b0, 1'b0, ST_IDLE, 1'b0, 8'd0);
    rstN = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
